// File: rtl/cordic_pkg.sv
// Shared constants, result record and gain-compensation helper for the CORDIC output stage.
package cordic_pkg;

  localparam int DATA_W   = 8;
  localparam int GAIN_SH1 = 1;
  localparam int GAIN_SH2 = 3;
  localparam int GAIN_SH3 = 6;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

  typedef struct packed {
    logic              mode;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } res_t;

  // v*K with K ~ 0.609, using floor shifts; magnitude never exceeds 78 so 8 bits suffice.
  function automatic logic [DATA_W-1:0] gain_comp(input logic [DATA_W-1:0] v);
    logic signed [DATA_W-1:0] s;
    s = $signed(v);
    return (s >>> GAIN_SH1) + (s >>> GAIN_SH2) - (s >>> GAIN_SH3);
  endfunction

endpackage

// File: rtl/cordic_res_fifo.sv
// Synchronous result FIFO; head entry is visible combinationally so the stage adds no read latency.
module cordic_res_fifo
  import cordic_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  res_t          din,
  output res_t          dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  res_t          mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CW'(1);
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally at AW bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  assign dout  = mem_reg[rd_ptr_reg];
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/cordic_out_stage.sv
// CORDIC result output stage: stage register + result FIFO with handshake and drop detection.
// Define CORDIC_GAIN_COMP_EN to apply K~0.609 gain compensation to rotation-mode results.
module cordic_out_stage
  import cordic_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_mode,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_mode,
  output logic              drop_err,
  output logic [4:0]        occupancy
);

  localparam int CW = $clog2(DEPTH) + 1;

  res_t          stage_reg;
  logic          stage_valid_reg;
  logic          drop_err_reg;
  res_t          in_res;
  res_t          head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          pop;
  logic          stage_move;
  logic          accept;

  always_comb begin
    in_res.mode = in_mode;
    in_res.a    = in_a;
    in_res.b    = in_b;
`ifdef CORDIC_GAIN_COMP_EN
    if (in_mode == MODE_ROT) begin
      in_res.a = gain_comp(in_a);
      in_res.b = gain_comp(in_b);
    end
`endif
  end

  assign pop        = out_valid && out_ready;
  assign stage_move = stage_valid_reg && (!fifo_full || pop);
  assign in_ready   = !stage_valid_reg || stage_move;
  assign accept     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid_reg <= 1'b0;
      drop_err_reg    <= 1'b0;
    end else begin
      if (accept) begin
        stage_valid_reg <= 1'b1;
        stage_reg       <= in_res;
      end else if (stage_move) begin
        stage_valid_reg <= 1'b0;
      end
      if (in_valid && !in_ready) begin
        drop_err_reg <= 1'b1;
      end
    end
  end

  cordic_res_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (stage_move),
    .pop   (pop),
    .din   (stage_reg),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Stale RAM contents are masked so an empty FIFO always presents zeros.
  assign out_valid = !fifo_empty;
  assign out_a     = fifo_empty ? '0 : head.a;
  assign out_b     = fifo_empty ? '0 : head.b;
  assign out_mode  = fifo_empty ? 1'b0 : head.mode;
  assign drop_err  = drop_err_reg;
  assign occupancy = 5'(fifo_count) + 5'(stage_valid_reg);

endmodule

// File: tb/tb_cordic_out_stage.sv
// Directed self-checking bench for cordic_out_stage; expectations follow CORDIC_GAIN_COMP_EN.
module tb_cordic_out_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_mode;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_a;
  logic [7:0] out_b;
  logic       out_mode;
  logic       drop_err;
  logic [4:0] occupancy;

  int checks   = 0;
  int failures = 0;

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic [7:0] ROT_A_EXP = 8'd61;
  localparam logic [7:0] ROT_B_EXP = 8'hC3;   // -61
  localparam logic [7:0] NEG_EXP   = 8'hB2;   // -78
`else
  localparam logic [7:0] ROT_A_EXP = 8'd100;
  localparam logic [7:0] ROT_B_EXP = 8'h9C;   // -100
  localparam logic [7:0] NEG_EXP   = 8'h80;   // -128
`endif

  always #5 clk = ~clk;

  cordic_out_stage #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_mode   (in_mode),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_mode  (out_mode),
    .drop_err  (drop_err),
    .occupancy (occupancy)
  );

  function automatic int fdiv(input int v, input int d);
    int q;
    q = v / d;
    if ((v % d) != 0 && v < 0) q = q - 1;
    return q;
  endfunction

  function automatic logic [7:0] exp_rot(input int v);
`ifdef CORDIC_GAIN_COMP_EN
    return 8'(fdiv(v, 2) + fdiv(v, 8) - fdiv(v, 64));
`else
    return 8'(v);
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic m, input int a, input int b);
    in_valid = v;
    in_mode  = m;
    in_a     = 8'(a);
    in_b     = 8'(b);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b0, 1'b0, 0, 0);
    out_ready = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
    checks++; if (occupancy !== 5'd0) begin failures++; $display("FAIL rst_occupancy got=%0d exp=0", occupancy); end
    checks++; if (drop_err !== 1'b0) begin failures++; $display("FAIL rst_drop_err got=%0b exp=0", drop_err); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
    checks++; if ({out_mode, out_a, out_b} !== 17'd0) begin failures++; $display("FAIL rst_out_data got=%0h exp=0", {out_mode, out_a, out_b}); end
  endtask

  task automatic test_rotation;
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 100, -100);
    tick;
    drive(1'b0, 1'b0, 0, 0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rot_early_valid got=%0b exp=0", out_valid); end
    tick;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rot_valid got=%0b exp=1", out_valid); end
    checks++; if (out_a !== ROT_A_EXP) begin failures++; $display("FAIL rot_out_a got=%0d exp=%0d", $signed(out_a), $signed(ROT_A_EXP)); end
    checks++; if (out_b !== ROT_B_EXP) begin failures++; $display("FAIL rot_out_b got=%0d exp=%0d", $signed(out_b), $signed(ROT_B_EXP)); end
    checks++; if (out_mode !== 1'b0) begin failures++; $display("FAIL rot_out_mode got=%0b exp=0", out_mode); end
    tick;
    checks++; if (occupancy !== 5'd0) begin failures++; $display("FAIL rot_drained got=%0d exp=0", occupancy); end
  endtask

  task automatic test_vectoring;
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 45, 3);
    tick;
    drive(1'b0, 1'b0, 0, 0);
    tick;
    checks++; if ({out_valid, out_mode} !== 2'b11) begin failures++; $display("FAIL vec_valid_mode got=%0b exp=11", {out_valid, out_mode}); end
    checks++; if (out_a !== 8'd45) begin failures++; $display("FAIL vec_out_a got=%0d exp=45", $signed(out_a)); end
    checks++; if (out_b !== 8'd3) begin failures++; $display("FAIL vec_out_b got=%0d exp=3", $signed(out_b)); end
    tick;
  endtask

  task automatic test_fill_drop;
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b1, 10 + k, -(10 + k));
      if (k == 5) begin
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready_6th got=%0b exp=0", in_ready); end
      end
      tick;
    end
    drive(1'b0, 1'b0, 0, 0);
    #1;
    checks++; if (occupancy !== 5'd5) begin failures++; $display("FAIL fill_occupancy got=%0d exp=5", occupancy); end
    checks++; if (drop_err !== 1'b1) begin failures++; $display("FAIL fill_drop_err got=%0b exp=1", drop_err); end
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (out_valid !== 1'b1 || out_a !== 8'(10 + k) || out_b !== 8'(-(10 + k)))
        begin failures++; $display("FAIL fill_drain_%0d got=%0d/%0d exp=%0d/%0d", k, $signed(out_a), $signed(out_b), 10 + k, -(10 + k)); end
      tick;
    end
    checks++; if (occupancy !== 5'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL fill_empty got=%0d exp=0", occupancy); end
  endtask

  task automatic test_full_pass_through;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 20 + k, k);
      tick;
    end
    drive(1'b0, 1'b0, 0, 0);
    #1;
    checks++; if (occupancy !== 5'd5) begin failures++; $display("FAIL full_occupancy got=%0d exp=5", occupancy); end
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 25, 5);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_in_ready_on_pop got=%0b exp=1", in_ready); end
    tick;
    drive(1'b0, 1'b0, 0, 0);
    checks++; if (occupancy !== 5'd5) begin failures++; $display("FAIL full_same_edge_occ got=%0d exp=5", occupancy); end
    checks++; if (drop_err !== 1'b1) begin failures++; $display("FAIL full_drop_err_held got=%0b exp=1", drop_err); end
    for (int k = 1; k < 6; k++) begin
      checks++; if (out_valid !== 1'b1 || out_a !== 8'(20 + k)) begin failures++; $display("FAIL full_order_%0d got=%0d exp=%0d", k, $signed(out_a), 20 + k); end
      tick;
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 30 + k, 0);
      tick;
    end
    drive(1'b0, 1'b0, 0, 0);
    #1;
    checks++; if (occupancy !== 5'd3) begin failures++; $display("FAIL mid_occupancy got=%0d exp=3", occupancy); end
    rst = 1'b1;
    drive(1'b1, 1'b0, 40, 40);
    tick;
    rst = 1'b0;
    drive(1'b0, 1'b0, 0, 0);
    #1;
    checks++; if (out_valid !== 1'b0 || occupancy !== 5'd0) begin failures++; $display("FAIL mid_rst_state got=%0b/%0d exp=0/0", out_valid, occupancy); end
    checks++; if (drop_err !== 1'b0) begin failures++; $display("FAIL mid_rst_drop_err got=%0b exp=0", drop_err); end
    checks++; if (out_a !== 8'd0 || in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_outputs got=%0d/%0b exp=0/1", out_a, in_ready); end
    out_ready = 1'b1;
    drive(1'b1, 1'b0, -128, 0);
    tick;
    drive(1'b0, 1'b0, 0, 0);
    tick;
    checks++; if (out_valid !== 1'b1 || out_a !== NEG_EXP) begin failures++; $display("FAIL mid_neg128 got=%0d exp=%0d", $signed(out_a), $signed(NEG_EXP)); end
    checks++; if (out_b !== 8'd0 || out_mode !== 1'b0) begin failures++; $display("FAIL mid_neg128_b got=%0d exp=0", $signed(out_b)); end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [16:0] exp_q[$];
    logic [16:0] got;
    int sent = 0;
    int recv = 0;
    int a_v;
    int b_v;
    logic m_v;
    for (int cyc = 0; cyc < 400 && recv < 20; cyc++) begin
      drive(1'b0, 1'b0, 0, 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        got = {out_mode, out_a, out_b};
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL b2b_unexpected got=%0h exp=none", got);
        end else begin
          if (got !== exp_q[0]) begin failures++; $display("FAIL b2b_item_%0d got=%0h exp=%0h", recv, got, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        $display("txn %0d mode=%0b a=%0d b=%0d", recv, out_mode, $signed(out_a), $signed(out_b));
        recv++;
      end
      if (sent < 20 && in_ready) begin
        m_v = sent[0];
        a_v = sent * 13 - 120;
        b_v = 7 - sent * 5;
        drive(1'b1, m_v, a_v, b_v);
        exp_q.push_back({m_v, m_v ? 8'(a_v) : exp_rot(a_v), m_v ? 8'(b_v) : exp_rot(b_v)});
        sent++;
      end
      tick;
    end
    drive(1'b0, 1'b0, 0, 0);
    checks++; if (recv != 20) begin failures++; $display("FAIL b2b_count got=%0d exp=20", recv); end
    checks++; if (drop_err !== 1'b0) begin failures++; $display("FAIL b2b_drop_err got=%0b exp=0", drop_err); end
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 1'b0, 0, 0);
    test_reset;
    test_rotation;
    test_vectoring;
    test_fill_drop;
    test_full_pass_through;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
